fft_frame_packer: RTL

Builds Avalon-ST frames for the audio FFT sink from a free-running audio sample strobe. Samples go into an internal FIFO, and the block emits FFT_PTS-point frames marked with sop/eop, honouring backpressure. It is the transmitter for the FFT core's sink port in the voice coder path: it drives sink_valid/sop/eop/real/imag/fftpts_in and responds to sink_ready. A frame is launched only when it is fully buffered, so a frame never starves mid-transfer.

---
 rtl/voice_pkg.sv | 26 ++
 rtl/sample_fifo.sv | 70 +++++++
 rtl/fft_frame_packer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// voice_pkg: shared defaults for the voice coder FFT packer, the packer
// FSM state type, and the Hann window coefficient generator.
package voice_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FFT_PTS    = 256;
  localparam int DEF_FIFO_DEPTH = 512;

  // Window coefficients are unsigned Q1.15; the largest value is 32767.
  localparam int COEF_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } pack_state_e;

  // w[k] = round(32767 * 0.5 * (1 - cos(2*pi*k/n))), rounding half up.
  // The tiny epsilon keeps exact .5 cases from falling just below the
  // rounding point because of floating-point error in cos().
  function automatic logic [COEF_W-1:0] hann_coef(input int k, input int n);
    real w;
    w = 32767.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(n)));
    return COEF_W'($rtoi($floor(w + 0.5 + 1.0e-9)));
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with a registered count. It has two
// combinational reads: the head entry and the entry after it. The frame
// packer uses the second read to stream one beat per cycle.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic                    push_ok_o,
  output logic [DATA_W-1:0]       head_o,
  output logic [DATA_W-1:0]       next_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]     count_q, count_d;

  // Fullness is judged only on the registered count. A pop in the same
  // cycle therefore never frees a slot for that cycle's push.
  assign push_ok_o = push_i && (count_q != FULL_CNT);
  assign rd_nxt    = rd_ptr_q + AW'(1);
  assign head_o    = mem_q[rd_ptr_q];
  assign next_o    = mem_q[rd_nxt];
  assign count_o   = count_q;

  // Sample storage, written only on an accepted push.
  // NOTE: the array has no reset. The pointers and the count say which
  // entries are valid, and a RAM with no reset can map onto memory blocks.
  always_ff @(posedge clk) begin
    if (push_ok_o) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Occupancy update. Push and pop in the same cycle cancel out.
  // NOTE: count_d gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push_ok_o, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers. The pointers wrap modulo DEPTH.
  // NOTE: state uses <= so every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_o) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)     rd_ptr_q <= rd_nxt;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: buffers strobed audio samples and sends them to the FFT
// sink as FFT_PTS-point Avalon-ST frames. A frame starts only once it is
// fully buffered. A sample stays in the FIFO until its beat is accepted, so
// the output register adds no hidden storage.
// Optional Hann windowing: define FFT_PACKER_WINDOW_EN.
module fft_frame_packer
  import voice_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FFT_PTS    = DEF_FFT_PTS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  audio_in,
  input  logic                      audio_valid,
  output logic                      src_valid,
  input  logic                      src_ready,
  output logic                      src_sop,
  output logic                      src_eop,
  output logic signed [DATA_W-1:0]  src_real,
  output logic signed [DATA_W-1:0]  src_imag,
  output logic [1:0]                src_error,
  output logic [$clog2(FFT_PTS):0]  fftpts,
  output logic                      overflow
);

  localparam int KW = $clog2(FFT_PTS);
  localparam int FW = KW + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [KW-1:0] LAST_K  = KW'(FFT_PTS - 1);
  localparam logic [CW-1:0] PTS_CNT = CW'(FFT_PTS);

  pack_state_e       state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head, fifo_next;
  logic              push_ok, pop, launch, launch_ok, load_next, xfer;
  logic [DATA_W-1:0] beat_sample, beat_value;
  logic              src_valid_q, src_sop_q, src_eop_q, overflow_q;
  logic [DATA_W-1:0] src_real_q;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (audio_valid),
    .push_data_i (audio_in),
    .pop_i       (pop),
    .push_ok_o   (push_ok),
    .head_o      (fifo_head),
    .next_o      (fifo_next),
    .count_o     (fifo_count)
  );

  assign xfer = src_valid_q && src_ready;

  // The output register shows the FIFO head. When a beat is accepted, that
  // entry is popped and the entry after it moves into the output register.
  // The first beat of a frame comes straight from the head.
  assign beat_sample = launch ? fifo_head : fifo_next;

  // Frame FSM: launch from IDLE once a whole frame is buffered. Stream one
  // beat per accepted cycle. After eop, chain into the next frame if a full
  // frame remains behind the eop sample.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    launch    = 1'b0;
    load_next = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_ok) begin
          launch  = 1'b1;
          k_d     = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          pop = 1'b1;
          k_d = k_q + KW'(1);
          if (k_q != LAST_K || fifo_count > PTS_CNT) begin
            load_next = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FFT_PACKER_WINDOW_EN
  localparam int PW = DATA_W + COEF_W + 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

  logic [COEF_W-1:0]    win_rom [FFT_PTS];
  logic [COEF_W-1:0]    coef_q;
  logic [KW-1:0]        coef_k;
  logic                 avail_q;
  logic signed [PW-1:0] prod, rounded;

  for (genvar i = 0; i < FFT_PTS; i++) begin : g_rom
    assign win_rom[i] = hann_coef(i, FFT_PTS);
  end

  // The coefficient is fetched one cycle early, for the beat that loads next.
  assign coef_k    = (state_d == IDLE) ? '0 : k_d + KW'(1);
  assign launch_ok = avail_q;

  // Window pipeline stage: registered ROM read plus a registered launch
  // qualifier. The IDLE count never falls, so avail_q cannot go stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_q  <= '0;
      avail_q <= 1'b0;
    end else begin
      coef_q  <= win_rom[coef_k];
      avail_q <= (state_q == IDLE) && (fifo_count >= PTS_CNT);
    end
  end

  // Q1.15 multiply with half-up rounding, saturated to DATA_W.
  always_comb begin
    prod       = PW'($signed(beat_sample)) * PW'($signed({1'b0, coef_q}));
    rounded    = (prod + PW'(16384)) >>> 15;
    beat_value = rounded[DATA_W-1:0];
    if (rounded > SAT_MAX) begin
      beat_value = SAT_MAX[DATA_W-1:0];
    end else if (rounded < SAT_MIN) begin
      beat_value = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  assign beat_value = beat_sample;
  assign launch_ok  = (fifo_count >= PTS_CNT);
`endif

  // FSM state, beat counter, sticky overflow and the registered Avalon-ST
  // outputs. With no load and no transfer, everything holds: that is the
  // stall behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      overflow_q  <= 1'b0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_real_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      overflow_q <= overflow_q | (audio_valid & ~push_ok);
      if (launch || load_next) begin
        src_valid_q <= 1'b1;
        src_sop_q   <= (k_d == '0);
        src_eop_q   <= (k_d == LAST_K);
        src_real_q  <= beat_value;
      end else if (xfer) begin
        src_valid_q <= 1'b0;
        src_sop_q   <= 1'b0;
        src_eop_q   <= 1'b0;
      end
    end
  end

  assign src_valid = src_valid_q;
  assign src_sop   = src_sop_q;
  assign src_eop   = src_eop_q;
  assign src_real  = src_real_q;
  assign src_imag  = '0;
  assign src_error = 2'b00;
  assign fftpts    = FW'(FFT_PTS);
  assign overflow  = overflow_q;

endmodule
